fpu_issue_ctrl: RTL and testbench

Issue/writeback controller sitting between the FP decode stage and the pipelined `fpu`; it is the initiator and consumer side of the FPU start/ready protocol. It accepts decoded FP instructions over a valid/ready handshake and blocks on register hazards and writeback-slot conflicts caused by the FPU's variable 4/5/6-cycle latency. It pulses the FPU start and tags each in-flight operation with its destination register, then writes the result back in order of completion. It also accumulates exception flags for the `fflags` CSR.

---
 rtl/fpu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue/writeback controller between the FP decode stage and a pipelined
//   FPU with a 4/5/6-cycle latency. It accepts decoded instructions over a
//   valid/ready handshake. It stalls on RAW/WAW register hazards and on
//   writeback-slot collisions, pulses the FPU start, and tags each in-flight
//   operation with its destination register. Results are written back one
//   cycle after the FPU signals ready. Exception flags accumulate into a
//   sticky fflags register.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   issue_valid/issue_ready   decode handshake
//   issue_funct7/funct3       operation encoding / rounding mode
//   issue_rd, issue_rs1..3    destination and source registers
//   issue_uses_rs3            rs3 is a real operand (FMA family)
//   fpu_op, fpu_funct7/3      FPU start pulse and operation fields
//   fpu_result/flags/ready    FPU completion
//   wb_valid, wb_rd, wb_data  register-file write port
//   fflags, fflags_clr        sticky exception flags and CSR clear
//   idle                      nothing in flight
//   err                       sticky protocol-violation flag
//
// Optional feature: define FPU_ISSUE_CHECK_EN to check the FPU ready
// protocol against the reservation register. Without it, err is tied low
// and fpu_ready is trusted blindly.
module fpu_issue_ctrl #(
    parameter int MAX_LAT = 6,
    parameter int NREGS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [6:0]  issue_funct7,
    input  logic [2:0]  issue_funct3,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rs3,
    input  logic        issue_uses_rs3,
    output logic        fpu_op,
    output logic [6:0]  fpu_funct7,
    output logic [2:0]  fpu_funct3,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        fpu_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        idle,
    output logic        err
);
    localparam int LW = $clog2(MAX_LAT + 1);

    // res_v[k] set means fpu_ready is due k cycles from now; res_tag[k] is
    // the destination register of that operation.
    logic [MAX_LAT:0] res_v;
    logic [4:0]       res_tag [0:MAX_LAT];
    logic [NREGS-1:0] busy;

    logic [LW-1:0]    lat;
    logic             stall;
    logic             accept;
    logic             done;
    logic [MAX_LAT:0] ins;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    function automatic logic [LW-1:0] lat_of(input logic [6:0] f7);
        case (f7[6:2])
            5'b00000, 5'b00001: lat_of = LW'(4);
            5'b00010:           lat_of = LW'(5);
            default:            lat_of = LW'(6);
        endcase
    endfunction

    // Issue stage: hazard and slot checks, start pulse
    always_comb begin
        lat         = lat_of(issue_funct7);
        stall       = res_v[lat]
                    | busy[issue_rs1]
                    | busy[issue_rs2]
                    | (busy[issue_rs3] & issue_uses_rs3)
                    | busy[issue_rd];
        issue_ready = ~rst & ~stall;
        accept      = issue_valid & issue_ready;
        // The reservation shifts at the same edge the tag is inserted, so a
        // latency-L op lands one slot below L.
        ins         = accept ? ((MAX_LAT + 1)'(1) << (lat - LW'(1))) : '0;
        set_mask    = accept ? (NREGS'(1) << issue_rd) : '0;
        // busy stays set through the writeback cycle itself, which is what
        // holds a dependent instruction off until T+L+2.
        clr_mask    = wb_valid ? (NREGS'(1) << wb_rd) : '0;
`ifdef FPU_ISSUE_CHECK_EN
        done        = fpu_ready & res_v[0];
`else
        done        = fpu_ready;
`endif
    end

    assign fpu_op     = accept;
    assign fpu_funct7 = issue_funct7;
    assign fpu_funct3 = issue_funct3;
    assign idle       = ~|res_v & ~|busy & ~wb_valid;

    // Reservation / writeback stage
    always_ff @(posedge clk) begin
        if (rst) begin
            res_v    <= '0;
            busy     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            fflags   <= 5'd0;
        end else begin
            res_v    <= {1'b0, res_v[MAX_LAT:1]} | ins;
            busy     <= (busy & ~clr_mask) | set_mask;
            wb_valid <= done;
            if (done) begin
                wb_rd   <= res_tag[0];
                wb_data <= fpu_result;
            end
            // A clear still keeps the flags of a same-cycle completion.
            if (fflags_clr)
                fflags <= done ? fpu_flags : 5'd0;
            else if (done)
                fflags <= fflags | fpu_flags;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_LAT; k++)
            res_tag[k] <= ins[k] ? issue_rd : res_tag[k+1];
        if (ins[MAX_LAT])
            res_tag[MAX_LAT] <= issue_rd;
    end

`ifdef FPU_ISSUE_CHECK_EN
    logic err_q;

    // Ready without a reservation, or a reservation without ready.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (fpu_ready != res_v[0])
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam logic [6:0] FADD = 7'b0000000;
    localparam logic [6:0] FSUB = 7'b0000100;
    localparam logic [6:0] FMUL = 7'b0001000;
    localparam logic [6:0] FMA  = 7'b0100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_funct7;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2, issue_rs3;
    logic        issue_uses_rs3;
    logic        fpu_op;
    logic [6:0]  fpu_funct7;
    logic [2:0]  fpu_funct3;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        fpu_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        idle;
    logic        err;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_funct7(issue_funct7), .issue_funct3(issue_funct3),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs3(issue_rs3), .issue_uses_rs3(issue_uses_rs3),
        .fpu_op(fpu_op), .fpu_funct7(fpu_funct7), .fpu_funct3(fpu_funct3),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fflags(fflags), .fflags_clr(fflags_clr), .idle(idle), .err(err)
    );

    // Behavioural model: completions scheduled by absolute cycle number,
    // and per-register cycle of the pending writeback.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } comp_t;

    comp_t       comp [int];
    int          wb_cyc [32];
    int          cyc;
    int          last_key;
    int          checks;
    int          errors;
    bit          e_wbv, e_rdk, e_err;
    logic [4:0]  e_rd, e_ff;
    logic [31:0] e_data;

    // Next-cycle stimulus
    bit          n_iv, n_u3, n_clr, n_rst, n_spur;
    logic [6:0]  n_f7;
    logic [2:0]  n_f3;
    logic [4:0]  n_rd, n_rs1, n_rs2, n_rs3;

    function automatic int lat_of(input logic [6:0] f7);
        if (f7[6:2] <= 5'd1) return 4;
        if (f7[6:2] == 5'd2) return 5;
        return 6;
    endfunction

    function automatic bit busy_m(input logic [4:0] r);
        return wb_cyc[r] >= cyc;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic present(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rs3, input bit u3, input bit v);
        n_f7 = f7; n_rd = rd; n_rs1 = rs1; n_rs2 = rs2; n_rs3 = rs3; n_u3 = u3; n_iv = v;
        n_f3 = 3'($urandom);
    endtask

    task automatic idle_in();
        present(FADD, 5'd20, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
    endtask

    // One clock cycle: drive, compare DUT against the model, advance model.
    task automatic cycle();
        bit          have, rdy_now, exp_rdy, acc, done, any_busy, e_idle;
        comp_t       ce;
        logic [31:0] d;
        logic [4:0]  fl;
        int          L;
        @(negedge clk);
        rst = n_rst; fflags_clr = n_clr;
        issue_valid = n_iv; issue_funct7 = n_f7; issue_funct3 = n_f3;
        issue_rd = n_rd; issue_rs1 = n_rs1; issue_rs2 = n_rs2; issue_rs3 = n_rs3;
        issue_uses_rs3 = n_u3;
        have = comp.exists(cyc);
        if (have) begin
            ce = comp[cyc]; d = ce.data; fl = ce.flags;
        end else begin
            d = $urandom; fl = 5'($urandom);
        end
        rdy_now    = have || n_spur;
        fpu_ready  = rdy_now;
        fpu_result = d;
        fpu_flags  = fl;
        #1;
        L = lat_of(n_f7);
        exp_rdy = !n_rst && !comp.exists(cyc + L) && !busy_m(n_rs1) && !busy_m(n_rs2)
                  && !(n_u3 && busy_m(n_rs3)) && !busy_m(n_rd);
        acc = n_iv && exp_rdy;
        any_busy = 1'b0;
        for (int r = 0; r < 32; r++) if (busy_m(5'(r))) any_busy = 1'b1;
        e_idle = (comp.num() == 0) && !any_busy && !e_wbv;

        chk("issue_ready", issue_ready, exp_rdy);
        chk("fpu_op", fpu_op, acc);
        chk("fpu_funct7", fpu_funct7, n_f7);
        chk("fpu_funct3", fpu_funct3, n_f3);
        chk("wb_valid", wb_valid, e_wbv);
        if (e_rdk) chk("wb_rd", wb_rd, e_rd);
        chk("wb_data", wb_data, e_data);
        chk("fflags", fflags, e_ff);
        chk("idle", idle, e_idle);
        chk("err", err, e_err);

`ifdef FPU_ISSUE_CHECK_EN
        done = have;
`else
        done = rdy_now;
`endif
        if (n_rst) begin
            comp.delete();
            for (int r = 0; r < 32; r++) wb_cyc[r] = -1;
            e_wbv = 0; e_rd = 0; e_rdk = 1; e_data = 0; e_ff = 0; e_err = 0;
        end else begin
            e_wbv = done;
            if (done) begin
                e_data = d;
                if (have) begin e_rd = ce.rd; e_rdk = 1; end
                else e_rdk = 0;
            end
            e_ff = n_clr ? (done ? fl : 5'd0) : (e_ff | (done ? fl : 5'd0));
`ifdef FPU_ISSUE_CHECK_EN
            if (rdy_now != have) e_err = 1;
`endif
            if (have) comp.delete(cyc);
            if (acc) begin
                ce.rd = n_rd; ce.data = $urandom; ce.flags = 5'($urandom);
                comp[cyc + L] = ce;
                wb_cyc[n_rd] = cyc + L + 1;
                last_key = cyc + L;
            end
        end
        cyc++;
        n_iv = 0; n_clr = 0; n_rst = 0; n_spur = 0;
    endtask

    task automatic drain();
        repeat (12) begin idle_in(); cycle(); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_key = -1;
        e_wbv = 0; e_rd = 0; e_rdk = 1; e_data = 0; e_ff = 0; e_err = 0;
        for (int r = 0; r < 32; r++) wb_cyc[r] = -1;
        rst = 1; issue_valid = 0; issue_funct7 = 0; issue_funct3 = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs3 = 0; issue_uses_rs3 = 0;
        fpu_result = 0; fpu_flags = 0; fpu_ready = 0; fflags_clr = 0;
        n_clr = 0; n_spur = 0;
        idle_in();
        repeat (2) @(posedge clk);

        // Reset state
        n_rst = 1; cycle();
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_err", err, 0);

        // Back-to-back independent FADDs
        for (int i = 0; i < 7; i++) begin
            if (i == 0) present(FADD, 5'd1, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else if (i == 1) present(FADD, 5'd2, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else idle_in();
            cycle();
            chk("t1_ready", issue_ready, 1);
            if (i == 5) begin chk("t1_wbv5", wb_valid, 1); chk("t1_rd5", wb_rd, 1); end
            if (i == 6) begin chk("t1_wbv6", wb_valid, 1); chk("t1_rd6", wb_rd, 2); end
        end
        drain();

        // Writeback slot collision: FMADD L=6 then FADD L=4
        for (int i = 0; i < 9; i++) begin
            if (i == 0) present(FMA, 5'd3, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1);
            else if (i == 2 || i == 3) present(FADD, 5'd4, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else idle_in();
            cycle();
            if (i == 2) chk("t2_collide", issue_ready, 0);
            if (i == 3) chk("t2_accept", fpu_op, 1);
            if (i == 7) begin chk("t2_wbv7", wb_valid, 1); chk("t2_rd7", wb_rd, 3); end
            if (i == 8) begin chk("t2_wbv8", wb_valid, 1); chk("t2_rd8", wb_rd, 4); end
        end
        drain();

        // RAW then WAW against an FMUL (L=5)
        for (int w = 0; w < 2; w++) begin
            present(FMUL, 5'd5, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1); cycle();
            chk("t3_fmul", fpu_op, 1);
            for (int i = 1; i <= 7; i++) begin
                if (w == 0) present(FSUB, 5'd6, 5'd5, 5'd11, 5'd12, 1'b0, 1'b1);
                else        present(FSUB, 5'd5, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
                cycle();
                chk(w == 0 ? "t3_raw" : "t3_waw", issue_ready, (i == 7) ? 1 : 0);
            end
            drain();
        end

        // Flag accumulation and clear-with-completion
        idle_in(); n_clr = 1; cycle();
        for (int i = 0; i < 13; i++) begin
            if (i == 0) present(FADD, 5'd7, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else if (i == 1) present(FADD, 5'd8, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else if (i == 7) present(FADD, 5'd9, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
            else idle_in();
            if (i == 11) n_clr = 1;
            cycle();
            if ((i == 0 || i == 1 || i == 7) && comp.exists(last_key))
                comp[last_key].flags = (i == 0) ? 5'b00001 : (i == 1) ? 5'b00100 : 5'b10000;
            if (i == 6)  chk("t4_acc", fflags, 5'b00101);
            if (i == 12) chk("t4_clr", fflags, 5'b10000);
        end

        // Reset in the middle of an FMADD
        for (int i = 0; i < 11; i++) begin
            if (i == 0) present(FMA, 5'd3, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1);
            else idle_in();
            if (i == 3) n_rst = 1;
            cycle();
            if (i == 4) begin chk("t5_idle", idle, 1); chk("t5_fflags", fflags, 0); end
            if (i >= 4) chk("t5_no_wb", wb_valid, 0);
        end

        // Spurious fpu_ready while idle
        drain();
        idle_in(); n_spur = 1; cycle();
        idle_in(); cycle();
`ifdef FPU_ISSUE_CHECK_EN
        chk("t6_err", err, 1);
        chk("t6_no_wb", wb_valid, 0);
`else
        chk("t6_err", err, 0);
`endif
        idle_in(); n_rst = 1; cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] f7;
            case ($urandom % 4)
                0: f7 = {5'b00000, 2'($urandom)};
                1: f7 = {5'b00001, 2'($urandom)};
                2: f7 = {5'b00010, 2'($urandom)};
                default: f7 = 7'($urandom);
            endcase
            present(f7, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                    5'($urandom % 8), 1'($urandom), ($urandom % 4) != 0);
            n_clr = ($urandom % 16) == 0;
            n_rst = ($urandom % 300) == 0;
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
